// File: rtl/sync_data_tx_if.sv
// Bundle for the source-side toggle-handshake CDC transmitter: producer
// valid/ready, the held data bus with its request toggle, and status.
interface sync_data_tx_if #(
  parameter int DW = 32
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          tx_req;
  logic [DW-1:0] tx_data;
  logic          ack_tgl;
  logic          busy;
  logic          proto_err;
  logic [15:0]   sent_count;

  // Environment side: producer plus far-domain receiver.
  modport master (
    output in_valid, in_data, ack_tgl,
    input  in_ready, tx_req, tx_data, busy, proto_err, sent_count
  );

  modport slave (
    input  in_valid, in_data, ack_tgl,
    output in_ready, tx_req, tx_data, busy, proto_err, sent_count
  );
endinterface

// File: rtl/sync_data_tx.sv
// Source-domain transmitter of a 2-phase req/ack CDC: launches words by
// toggling tx_req over a held bus, with a one-word pending buffer.
module sync_data_tx #(
  parameter int DW         = 32,
  parameter int SYNC_DEPTH = 2
) (
  input logic           clk,
  input logic           rst_n,
  sync_data_tx_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [SYNC_DEPTH-1:0] ack_sync_q;
  logic                  ack_s;
  logic                  tx_req_q;
  logic [DW-1:0]         tx_data_q;
  logic [DW-1:0]         pend_q;
  logic                  pend_valid_q;
  logic                  proto_err_q;
  logic [15:0]           sent_count_q;

  logic aligned, misaligned, done, free;
  logic launch_pend, launch_in, launch, capture;

  assign ack_s = ack_sync_q[SYNC_DEPTH-1];

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: default first, so no path through the comb block leaves
  // state_d unassigned and a latch is never inferred.
  always_comb begin
    state_d = state_q;
    if (launch)    state_d = BUSY;
    else if (done) state_d = IDLE;
  end

  // An ack that moves while IDLE is realigned, never counted as completion.
  always_comb begin
    aligned     = (ack_s == tx_req_q);
    misaligned  = (state_q == IDLE) && !aligned;
    done        = (state_q == BUSY) && aligned;
    free        = ((state_q == IDLE) && aligned) || done;
    launch_pend = free && pend_valid_q;
    launch_in   = free && !pend_valid_q && bus.in_valid;
    launch      = launch_pend || launch_in;
    capture     = !free && bus.in_valid && !pend_valid_q;
  end

  // ack_tgl is asynchronous to clk; only the last stage is ever used.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ack_sync_q <= '0;
    else        ack_sync_q <= {ack_sync_q[SYNC_DEPTH-2:0], bus.ack_tgl};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_req_q     <= 1'b0;
      tx_data_q    <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      proto_err_q  <= 1'b0;
      sent_count_q <= '0;
    end else begin
      proto_err_q <= misaligned;

      // tx_data only moves on the edge that toggles tx_req.
      if (misaligned) begin
        tx_req_q <= ack_s;
      end else if (launch) begin
        tx_req_q  <= ~tx_req_q;
        tx_data_q <= launch_pend ? pend_q : bus.in_data;
      end

      if (launch_pend) begin
        pend_valid_q <= 1'b0;
      end else if (capture) begin
        pend_q       <= bus.in_data;
        pend_valid_q <= 1'b1;
      end

      if (done) sent_count_q <= sent_count_q + 16'd1;
    end
  end

  assign bus.in_ready   = ~pend_valid_q;
  assign bus.tx_req     = tx_req_q;
  assign bus.tx_data    = tx_data_q;
  assign bus.busy       = (state_q == BUSY);
  assign bus.proto_err  = proto_err_q;
  assign bus.sent_count = sent_count_q;

endmodule

// File: tb/tb_sync_data_tx.sv
// Bench for sync_data_tx: a cycle table with a hand-driven ack, then
// sequences against a behavioural far-domain receiver.
module tb_sync_data_tx;

  logic clk = 1'b0;
  logic rst_n;

  sync_data_tx_if #(.DW(32)) bus ();

  sync_data_tx #(.DW(32), .SYNC_DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [31:0] d;
    logic        ack;
    logic        rdy;
    logic        req;
    logic [31:0] data;
    logic        bsy;
    logic        perr;
    logic [15:0] cnt;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  // Far-domain receiver model state.
  bit          rx_en   = 1'b0;
  bit          rx_rand = 1'b0;
  int          rx_delay = 3;
  int          rx_wait  = 0;
  logic        rx_seen  = 1'b0;
  logic [31:0] rx_q[$];

  bit          mon_en = 1'b0;
  logic        prev_req;
  logic [31:0] prev_data;
  logic [31:0] src[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock: inputs and outputs both live at the falling edge.
  task automatic step();
    @(negedge clk);
    if (mon_en && bus.tx_req == prev_req) check("data_stable", bus.tx_data, prev_data);
    prev_req  = bus.tx_req;
    prev_data = bus.tx_data;
    if (rx_en) begin
      if (rx_wait > 0) begin
        rx_wait--;
        if (rx_wait == 0) bus.ack_tgl = ~bus.ack_tgl;
      end
      if (bus.tx_req != rx_seen) begin
        rx_seen = bus.tx_req;
        rx_q.push_back(bus.tx_data);
        if (rx_rand) rx_delay = int'($urandom_range(0, 20));
        if (rx_delay == 0) bus.ack_tgl = ~bus.ack_tgl;
        else               rx_wait = rx_delay;
      end
    end
  endtask

  task automatic do_reset();
    rx_en        = 1'b0;
    mon_en       = 1'b0;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.ack_tgl  = 1'b0;
    rx_seen      = 1'b0;
    rx_wait      = 0;
    rx_q.delete();
    step();
    step();
    rst_n = 1'b1;
  endtask

  // Producer holds in_valid until every word in src is accepted, then
  // waits for all of them to complete.
  task automatic run_stream(input int n, output bit gap, output bit saw_full);
    int idx = 0;
    int cyc = 0;
    bit acc;
    gap          = 1'b0;
    saw_full     = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = src[0];
    while (bus.sent_count != 16'(n) && cyc < 3000) begin
      acc = bus.in_valid && bus.in_ready;
      step();
      cyc++;
      if (bus.busy && !bus.in_ready) saw_full = 1'b1;
      if (!bus.busy && bus.sent_count != 16'(n)) gap = 1'b1;
      if (acc) begin
        idx++;
        if (idx < n) bus.in_data = src[idx];
        else begin
          bus.in_valid = 1'b0;
          bus.in_data  = '0;
        end
      end
    end
    check("stream_done", bus.sent_count, 32'(n));
  endtask

  vec_t vecs[23];
  localparam logic [31:0] A1 = 32'hA000_0001, A2 = 32'hA000_0002, A3 = 32'hA000_0003,
                          A4 = 32'hA000_0004, A5 = 32'hA000_0005;

  initial begin
    bit gap, saw_full;
    int cyc, perr_seen;

    //          iv    d     ack | rdy  req  data bsy  perr cnt
    vecs[0]  = '{1'b1, A1, 1'b0, 1'b1, 1'b1, A1, 1'b1, 1'b0, 16'd0};
    vecs[1]  = '{1'b1, A2, 1'b0, 1'b0, 1'b1, A1, 1'b1, 1'b0, 16'd0};
    vecs[2]  = '{1'b1, A3, 1'b1, 1'b0, 1'b1, A1, 1'b1, 1'b0, 16'd0};
    vecs[3]  = '{1'b1, A3, 1'b1, 1'b0, 1'b1, A1, 1'b1, 1'b0, 16'd0};
    vecs[4]  = '{1'b1, A3, 1'b1, 1'b1, 1'b0, A2, 1'b1, 1'b0, 16'd1};
    vecs[5]  = '{1'b1, A3, 1'b1, 1'b0, 1'b0, A2, 1'b1, 1'b0, 16'd1};
    vecs[6]  = '{1'b0, 0,  1'b0, 1'b0, 1'b0, A2, 1'b1, 1'b0, 16'd1};
    vecs[7]  = '{1'b0, 0,  1'b0, 1'b0, 1'b0, A2, 1'b1, 1'b0, 16'd1};
    vecs[8]  = '{1'b0, 0,  1'b0, 1'b1, 1'b1, A3, 1'b1, 1'b0, 16'd2};
    vecs[9]  = '{1'b0, 0,  1'b1, 1'b1, 1'b1, A3, 1'b1, 1'b0, 16'd2};
    vecs[10] = '{1'b0, 0,  1'b1, 1'b1, 1'b1, A3, 1'b1, 1'b0, 16'd2};
    vecs[11] = '{1'b1, A4, 1'b1, 1'b1, 1'b0, A4, 1'b1, 1'b0, 16'd3};
    vecs[12] = '{1'b0, 0,  1'b0, 1'b1, 1'b0, A4, 1'b1, 1'b0, 16'd3};
    vecs[13] = '{1'b0, 0,  1'b0, 1'b1, 1'b0, A4, 1'b1, 1'b0, 16'd3};
    vecs[14] = '{1'b0, 0,  1'b0, 1'b1, 1'b0, A4, 1'b0, 1'b0, 16'd4};
    vecs[15] = '{1'b0, 0,  1'b0, 1'b1, 1'b0, A4, 1'b0, 1'b0, 16'd4};
    vecs[16] = '{1'b0, 0,  1'b1, 1'b1, 1'b0, A4, 1'b0, 1'b0, 16'd4};
    vecs[17] = '{1'b0, 0,  1'b1, 1'b1, 1'b0, A4, 1'b0, 1'b0, 16'd4};
    vecs[18] = '{1'b1, A5, 1'b1, 1'b0, 1'b1, A4, 1'b0, 1'b1, 16'd4};
    vecs[19] = '{1'b0, 0,  1'b1, 1'b1, 1'b0, A5, 1'b1, 1'b0, 16'd4};
    vecs[20] = '{1'b0, 0,  1'b0, 1'b1, 1'b0, A5, 1'b1, 1'b0, 16'd4};
    vecs[21] = '{1'b0, 0,  1'b0, 1'b1, 1'b0, A5, 1'b1, 1'b0, 16'd4};
    vecs[22] = '{1'b0, 0,  1'b0, 1'b1, 1'b0, A5, 1'b0, 1'b0, 16'd5};

    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.ack_tgl  = 1'b0;
    rst_n        = 1'b0;
    step();
    check("rst.in_ready", bus.in_ready, 1);
    check("rst.tx_req", bus.tx_req, 0);
    check("rst.tx_data", bus.tx_data, 0);
    check("rst.busy", bus.busy, 0);
    check("rst.proto_err", bus.proto_err, 0);
    check("rst.sent_count", bus.sent_count, 0);

    // Cycle table with the ack toggle driven directly.
    do_reset();
    for (int i = 0; i < 23; i++) begin
      bus.in_valid = vecs[i].iv;
      bus.in_data  = vecs[i].d;
      bus.ack_tgl  = vecs[i].ack;
      step();
      check($sformatf("vec%0d.in_ready", i), bus.in_ready, vecs[i].rdy);
      check($sformatf("vec%0d.tx_req", i), bus.tx_req, vecs[i].req);
      check($sformatf("vec%0d.tx_data", i), bus.tx_data, vecs[i].data);
      check($sformatf("vec%0d.busy", i), bus.busy, vecs[i].bsy);
      check($sformatf("vec%0d.proto_err", i), bus.proto_err, vecs[i].perr);
      check($sformatf("vec%0d.sent_count", i), bus.sent_count, vecs[i].cnt);
    end

    // Single word with a receiver acking 3 cycles after the req edge.
    do_reset();
    rx_en = 1'b1; rx_rand = 1'b0; rx_delay = 3;
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hDEAD_BEEF;
    step();
    bus.in_valid = 1'b0;
    check("single.tx_req", bus.tx_req, 1);
    check("single.tx_data", bus.tx_data, 32'hDEAD_BEEF);
    check("single.busy", bus.busy, 1);
    cyc = 0;
    while (bus.ack_tgl == 1'b0 && cyc < 50) begin
      step();
      cyc++;
    end
    check("single.ack_seen", bus.ack_tgl, 1);
    step();
    step();
    check("single.busy_held", bus.busy, 1);
    step();
    check("single.busy_fall", bus.busy, 0);
    check("single.sent_count", bus.sent_count, 1);
    check("single.rx_word", rx_q[0], 32'hDEAD_BEEF);

    // Back-to-back 1,2,3 with in_valid held.
    do_reset();
    rx_en = 1'b1; rx_rand = 1'b0; rx_delay = 3; mon_en = 1'b1;
    prev_req = bus.tx_req; prev_data = bus.tx_data;
    src.delete();
    src.push_back(32'd1); src.push_back(32'd2); src.push_back(32'd3);
    run_stream(3, gap, saw_full);
    check("b2b.no_idle_gap", 32'(gap), 0);
    check("b2b.pend_full_seen", 32'(saw_full), 1);
    check("b2b.busy_end", bus.busy, 0);
    check("b2b.rx_count", rx_q.size(), 3);
    for (int i = 0; i < 3; i++) check($sformatf("b2b.rx%0d", i), rx_q[i], src[i]);

    // Random receiver delay 0..20 with the data-stability monitor on.
    do_reset();
    rx_en = 1'b1; rx_rand = 1'b1; mon_en = 1'b1;
    prev_req = bus.tx_req; prev_data = bus.tx_data;
    src.delete();
    for (int i = 0; i < 8; i++) src.push_back($urandom);
    run_stream(8, gap, saw_full);
    check("rand.no_idle_gap", 32'(gap), 0);
    check("rand.rx_count", rx_q.size(), 8);
    for (int i = 0; i < 8; i++) check($sformatf("rand.rx%0d", i), rx_q[i], src[i]);
    mon_en = 1'b0; rx_rand = 1'b0; rx_delay = 3;

    // Reset mid-transfer with pend full, far side left with ack at 1.
    do_reset();
    rx_en = 1'b1;
    src.delete();
    src.push_back(32'h11);
    run_stream(1, gap, saw_full);
    rx_en = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 32'h22;
    step();
    bus.in_data = 32'h33;
    step();
    bus.in_valid = 1'b0;
    check("mid.busy", bus.busy, 1);
    check("mid.in_ready", bus.in_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    check("arst.tx_req", bus.tx_req, 0);
    check("arst.busy", bus.busy, 0);
    check("arst.in_ready", bus.in_ready, 1);
    check("arst.sent_count", bus.sent_count, 0);
    check("arst.tx_data", bus.tx_data, 0);
    step();
    rst_n = 1'b1;
    check("arst.far_ack", bus.ack_tgl, 1);
    perr_seen = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      check($sformatf("realign%0d.busy", i), bus.busy, 0);
      if (bus.proto_err) begin
        perr_seen++;
        check("realign.tx_req", bus.tx_req, 1);
      end
    end
    check("realign.perr_pulses", perr_seen, 1);
    check("realign.sent_count", bus.sent_count, 0);
    rx_seen = bus.tx_req;
    rx_q.delete();
    rx_en = 1'b1;
    bus.in_valid = 1'b1; bus.in_data = 32'h44;
    step();
    bus.in_valid = 1'b0;
    check("post.tx_req", bus.tx_req, 0);
    check("post.tx_data", bus.tx_data, 32'h44);
    check("post.busy", bus.busy, 1);
    cyc = 0;
    while (bus.sent_count != 16'd1 && cyc < 50) begin
      step();
      cyc++;
    end
    check("post.sent_count", bus.sent_count, 1);
    check("post.rx_count", rx_q.size(), 1);
    check("post.rx_word", rx_q[0], 32'h44);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
